// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES block/key-index widths, sequencer state type and GF(2^8) byte helpers
package aes_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_KIDX_W = 4;
  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} aes_state_e;

  function automatic bit nr_legal(input int nr);
    return (nr == AES_NR_128) || (nr == AES_NR_192) || (nr == AES_NR_256);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Inverse computed as b^254, which conveniently maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    p = b;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
    logic [7:0] a;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - combinational AES inverse round
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns, mixing skipped when last=1.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state,
  input  logic [AES_BLK_W-1:0] rk,
  input  logic                 last,
  output logic [AES_BLK_W-1:0] next_state
);

  logic [7:0] ak [16];

  for (genvar c = 0; c < 4; c++) begin : g_col
    // Byte 4c+r sits at row r, column c; row r rotates right by r.
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC = 4 * ((c - r + 4) % 4) + r;
      localparam int DST = 4 * c + r;
      assign ak[DST] = inv_sub_byte(state[AES_BLK_W-1-8*SRC -: 8]) ^ rk[AES_BLK_W-1-8*DST -: 8];
    end

    logic [31:0] mix;
    assign mix = {mul0e(ak[4*c]) ^ mul0b(ak[4*c+1]) ^ mul0d(ak[4*c+2]) ^ mul09(ak[4*c+3]),
                  mul09(ak[4*c]) ^ mul0e(ak[4*c+1]) ^ mul0b(ak[4*c+2]) ^ mul0d(ak[4*c+3]),
                  mul0d(ak[4*c]) ^ mul09(ak[4*c+1]) ^ mul0e(ak[4*c+2]) ^ mul0b(ak[4*c+3]),
                  mul0b(ak[4*c]) ^ mul0d(ak[4*c+1]) ^ mul09(ak[4*c+2]) ^ mul0e(ak[4*c+3])};

    assign next_state[AES_BLK_W-1-32*c -: 32] =
      last ? {ak[4*c], ak[4*c+1], ak[4*c+2], ak[4*c+3]} : mix;
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// rtl/aes_inv_cipher_ctrl.sv - iterative AES inverse-cipher sequencer, one round per clock
// Optional macro AES_INV_FLUSH_EN adds a synchronous flush input that aborts the current block.
module aes_inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AES_BLK_W-1:0]  in_data,
  output logic [AES_KIDX_W-1:0] rk_idx,
  input  logic [AES_BLK_W-1:0]  rk_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AES_BLK_W-1:0]  out_data,
`ifdef AES_INV_FLUSH_EN
  input  logic                  flush,
`endif
  output logic                  busy
);

  if (!nr_legal(NR)) begin : g_bad_nr
    $error("aes_inv_cipher_ctrl: NR must be 10, 12 or 14");
  end

  localparam logic [AES_KIDX_W-1:0] CTR_INIT  = AES_KIDX_W'(NR - 1);
  localparam logic [AES_KIDX_W-1:0] KIDX_LAST = AES_KIDX_W'(NR);

  aes_state_e            state_q, state_d;
  logic [AES_KIDX_W-1:0] ctr_q, ctr_d;
  logic [AES_BLK_W-1:0]  blk_q, blk_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic [AES_KIDX_W-1:0] rk_idx_q, rk_idx_d;
  logic [AES_BLK_W-1:0]  round_out;

  aes_inv_round u_round (
    .state      (blk_q),
    .rk         (rk_data),
    .last       (state_q == FINAL),
    .next_state (round_out)
  );

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    blk_d   = blk_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          blk_d   = in_data ^ rk_data;
          ctr_d   = CTR_INIT;
          state_d = ROUND;
        end
      end
      ROUND: begin
        blk_d = round_out;
        ctr_d = ctr_q - 1'b1;
        if (ctr_q == AES_KIDX_W'(1)) state_d = FINAL;
      end
      FINAL: begin
        blk_d   = round_out;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef AES_INV_FLUSH_EN
    if (flush) begin
      state_d = IDLE;
      blk_d   = '0;
      ctr_d   = CTR_INIT;
    end
`endif
    // Outputs are decoded from the next state so they come straight off flops.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    case (state_d)
      IDLE:    rk_idx_d = KIDX_LAST;
      ROUND:   rk_idx_d = ctr_d;
      default: rk_idx_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ctr_q       <= CTR_INIT;
      blk_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rk_idx_q    <= KIDX_LAST;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      blk_q       <= blk_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rk_idx_q    <= rk_idx_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign rk_idx    = rk_idx_q;
  assign out_data  = blk_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// tb/tb_aes_inv_cipher_ctrl.sv - self-checking bench for aes_inv_cipher_ctrl (NR=10 and NR=14 instances)
// Flush scenarios are exercised when AES_INV_FLUSH_EN is defined.
module tb_aes_inv_cipher_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [127:0] in_data   [2];
  logic [3:0]   rk_idx    [2];
  logic [127:0] rk_data   [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] out_data  [2];
  logic         busy      [2];
`ifdef AES_INV_FLUSH_EN
  logic         flush     [2];
`endif

  logic [127:0] rk [2][16];
  int           nr_of [2];
  int           total;
  int           bad;
  int           cyc = 0;

  logic [7:0]   exp_t [256];
  int           log_t [256];
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];

  always @(posedge clk) cyc <= cyc + 1;

  assign rk_data[0] = rk[0][rk_idx[0]];
  assign rk_data[1] = rk[1][rk_idx[1]];

  aes_inv_cipher_ctrl #(.NR(10)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .rk_idx    (rk_idx[0]),
    .rk_data   (rk_data[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_data  (out_data[0]),
`ifdef AES_INV_FLUSH_EN
    .flush     (flush[0]),
`endif
    .busy      (busy[0])
  );

  aes_inv_cipher_ctrl #(.NR(14)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .rk_idx    (rk_idx[1]),
    .rk_data   (rk_data[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_data  (out_data[1]),
`ifdef AES_INV_FLUSH_EN
    .flush     (flush[1]),
`endif
    .busy      (busy[1])
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  // Log/antilog tables over generator 3, then S-box from inverse + forward affine map.
  task automatic build_tables();
    logic [7:0] x, inv, s;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x ^ xt(x);
    end
    exp_t[255] = 8'h01;
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : exp_t[(255 - log_t[a]) % 255];
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[a]  = s;
      isbox[s] = 8'(a);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand(input int d, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nr = nr_of[d];
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) rk[d][i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [7:0] byte_at(input logic [127:0] v, input int r, input int c);
    return v[127-8*(4*c+r) -: 8];
  endfunction

  function automatic logic [127:0] model_dec(input int d, input logic [127:0] ct);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   coef [4];
    logic [127:0] v, res;
    int nr;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    nr = nr_of[d];
    v = ct ^ rk[d][nr];
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] = byte_at(v, r, c);
    for (int rnd = nr - 1; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = isbox[s[r][(c - r + 4) % 4]] ^ byte_at(rk[d][rnd], r, c);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd == 0) s[r][c] = t[r][c];
          else begin
            s[r][c] = 8'h00;
            for (int k = 0; k < 4; k++) s[r][c] = s[r][c] ^ gm(coef[(k - r + 4) % 4], t[k][c]);
          end
        end
    end
    res = '0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input int d, input logic [127:0] blk, input bit keep);
    int n;
    @(negedge clk);
    in_data[d]  = blk;
    in_valid[d] = 1'b1;
    n = 0;
    while (!in_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 128'(n < 200), 128'd1);
    @(posedge clk);
    #1;
    if (!keep) in_valid[d] = 1'b0;
  endtask

  // n counts edges after the accepting edge until out_valid is seen.
  task automatic wait_out(input int d, output int n, output logic [127:0] data);
    n = 0;
    @(negedge clk);
    while (!out_valid[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    data = out_data[d];
  endtask

  initial begin
    logic [127:0] got, blk;
    logic [127:0] exp_q [$];
    logic [127:0] got_q [$];
    logic [63:0]  seq, exp_seq;
    int           acc_t [$];
    int           n, errs;

    total = 0;
    bad   = 0;
    nr_of[0] = 10;
    nr_of[1] = 14;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b0;
`ifdef AES_INV_FLUSH_EN
      flush[d]     = 1'b0;
`endif
    end
    build_tables();
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 128'(in_ready[d]), 128'd1);
      chk("rst_out_valid", 128'(out_valid[d]), 128'd0);
      chk("rst_out_data", out_data[d], 128'd0);
      chk("rst_busy", 128'(busy[d]), 128'd0);
      chk("rst_rk_idx", 128'(rk_idx[d]), 128'(nr_of[d]));
    end
    reset = 1'b0;

    // FIPS-197 C.1 vector, then hold the result under backpressure.
    send(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);
    wait_out(0, n, got);
    chk("c1_latency", 128'(n), 128'd10);
    chk("c1_plain", got, 128'h00112233445566778899aabbccddeeff);

    blk = rnd128();
    in_data[0]  = blk;
    in_valid[0] = 1'b1;
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_data[0] !== 128'h00112233445566778899aabbccddeeff || !out_valid[0] || in_ready[0]) errs++;
    end
    chk("bp_hold", 128'(errs), 128'd0);
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_out_drop", 128'(out_valid[0]), 128'd0);
    chk("bp_in_ready", 128'(in_ready[0]), 128'd1);
    chk("bp_not_yet", 128'(busy[0]), 128'd0);
    @(negedge clk);
    chk("bp_accepted", 128'(rk_idx[0]), 128'd9);
    in_valid[0] = 1'b0;
    wait_out(0, n, got);
    chk("bp_next_plain", got, model_dec(0, blk));

    // FIPS-197 C.3 vector on the NR=14 instance, tracking requested key indices.
    out_ready[1] = 1'b1;
    @(negedge clk);
    in_data[1]  = 128'h8ea2b7ca516745bfeafc49904b496089;
    in_valid[1] = 1'b1;
    seq = {60'h0, rk_idx[1]};
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid[1] && n < 100) begin
      seq = {seq[59:0], rk_idx[1]};
      @(negedge clk);
      n++;
    end
    got = out_data[1];
    exp_seq = '0;
    for (int i = 14; i >= 0; i--) exp_seq = {exp_seq[59:0], 4'(i)};
    chk("c3_rk_seq", 128'(seq), 128'(exp_seq));
    chk("c3_latency", 128'(n), 128'd14);
    chk("c3_plain", got, 128'h00112233445566778899aabbccddeeff);

    // Back-to-back random blocks under a random key.
    expand(0, {rnd128(), 128'h0});
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          int w;
          blk = rnd128();
          exp_q.push_back(model_dec(0, blk));
          @(negedge clk);
          in_data[0]  = blk;
          in_valid[0] = 1'b1;
          w = 0;
          while (!in_ready[0] && w < 100) begin
            @(negedge clk);
            w++;
          end
          @(posedge clk);
          #1;
          acc_t.push_back(cyc);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
      end
      begin
        repeat (8 * 12 + 40) begin
          @(negedge clk);
          if (out_valid[0]) got_q.push_back(out_data[0]);
        end
      end
    join
    chk("b2b_count", 128'(got_q.size()), 128'd8);
    for (int k = 0; k < 8 && k < got_q.size(); k++) chk("b2b_data", got_q[k], exp_q[k]);
    errs = 0;
    for (int k = 1; k < acc_t.size(); k++) if (acc_t[k] - acc_t[k-1] != 12) errs++;
    chk("b2b_accepts", 128'(acc_t.size()), 128'd8);
    chk("b2b_interval", 128'(errs), 128'd0);

    // Reset in the fifth ROUND cycle abandons the block.
    send(0, rnd128(), 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
    chk("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("mid_rst_busy", 128'(busy[0]), 128'd0);
    chk("mid_rst_rk_idx", 128'(rk_idx[0]), 128'd10);
    chk("mid_rst_out_data", out_data[0], 128'd0);
    @(negedge clk);
    reset = 1'b0;
    errs = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid[0] || busy[0]) errs++;
    end
    chk("mid_rst_quiet", 128'(errs), 128'd0);
    blk = rnd128();
    send(0, blk, 1'b0);
    wait_out(0, n, got);
    chk("post_rst_latency", 128'(n), 128'd10);
    chk("post_rst_plain", got, model_dec(0, blk));

`ifdef AES_INV_FLUSH_EN
    send(0, rnd128(), 1'b0);
    repeat (3) @(negedge clk);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    chk("flush_in_ready", 128'(in_ready[0]), 128'd1);
    chk("flush_busy", 128'(busy[0]), 128'd0);
    chk("flush_rk_idx", 128'(rk_idx[0]), 128'd10);
    chk("flush_state_clr", out_data[0], 128'd0);
    @(negedge clk);
    in_data[0]  = rnd128();
    in_valid[0] = 1'b1;
    flush[0]    = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    flush[0]    = 1'b0;
    chk("flush_hs_busy", 128'(busy[0]), 128'd0);
    chk("flush_hs_in_ready", 128'(in_ready[0]), 128'd1);
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid[0]) errs++;
    end
    chk("flush_no_out", 128'(errs), 128'd0);
    blk = rnd128();
    send(0, blk, 1'b0);
    wait_out(0, n, got);
    chk("post_flush_plain", got, model_dec(0, blk));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
